// File: rtl/vga_pkg.sv
// Shared constants for the VGA text display path: screen geometry, buffer
// word packing and sync polarity.
package vga_pkg;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int H_TILES         = 80;
    localparam int V_TILES         = 30;
    localparam int SINGLE_DATA     = 7;
    localparam int DATA_WIDTH      = 28;
    localparam int COLOR_WIDTH     = 12;
    localparam int FONT_ADDR_WIDTH = 11;
    localparam int ADDR_WIDTH      = 10;

    localparam int CHARS_PER_WORD  = DATA_WIDTH / SINGLE_DATA;
    localparam int WORDS_PER_ROW   = H_TILES / CHARS_PER_WORD;

    // Syncs are active-low; the idle level is also their reset value.
    localparam logic SYNC_ACTIVE   = 1'b0;
    localparam logic SYNC_IDLE     = ~SYNC_ACTIVE;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a
// parameterised value; used to align sidebands with the pixel pipeline.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain; every stage returns to RESET_VAL on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else begin
            stage_r[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q_o = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_tile_fetch.sv
// Display-side text reader: pixel coordinates -> buffer word -> font row ->
// RGB, as a fixed three-stage pipeline with a blinking block cursor.
module vga_tile_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
    parameter int H_TILES         = vga_pkg::H_TILES,
    parameter int ADDR_WIDTH      = vga_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = vga_pkg::DATA_WIDTH,
    parameter int SINGLE_DATA     = vga_pkg::SINGLE_DATA,
    parameter int FONT_ADDR_WIDTH = vga_pkg::FONT_ADDR_WIDTH,
    parameter int COLOR_WIDTH     = vga_pkg::COLOR_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [9:0]                 hcount_i,
    input  logic [9:0]                 vcount_i,
    input  logic                       hsync_i,
    input  logic                       vsync_i,
    output logic [ADDR_WIDTH-1:0]      vr_addr_o,
    input  logic [DATA_WIDTH-1:0]      buf_data_i,
    output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
    input  logic [7:0]                 font_data_i,
    input  logic [COLOR_WIDTH-1:0]     fg_color_i,
    input  logic [COLOR_WIDTH-1:0]     bg_color_i,
    input  logic                       cursor_en_i,
    input  logic [6:0]                 cursor_col_i,
    input  logic [4:0]                 cursor_row_i,
    output logic [COLOR_WIDTH-1:0]     rgb_o,
    output logic                       hsync_o,
    output logic                       vsync_o
);

    localparam int WPR = H_TILES / (DATA_WIDTH / SINGLE_DATA);

    logic                   active_s;
    logic [6:0]             col_s;
    logic [5:0]             row_s;
    logic [ADDR_WIDTH-1:0]  addr_s;
    logic                   hit_s;
    logic [1:0]             lane_r;
    logic [3:0]             glyph_row_r;
    logic [SINGLE_DATA-1:0] char_s;
    logic [4:0]             side_s;
    logic [4:0]             side_d_s;
    logic                   active_d_s;
    logic                   hit_d_s;
    logic [2:0]             hpix_d_s;
    logic [1:0]             sync_d_s;
    logic                   vsync_prev_r;
    logic [4:0]             frame_cnt_r;
    logic                   blink_s;
    logic                   pix_bit_s;
    logic [COLOR_WIDTH-1:0] rgb_s;

    // Stage 1 decode: tile coordinates, word address and cursor hit.
    always_comb begin
        active_s = (hcount_i < 10'(H_ACTIVE)) && (vcount_i < 10'(V_ACTIVE));
        col_s    = hcount_i[9:3];
        row_s    = vcount_i[9:4];
        addr_s   = ADDR_WIDTH'(row_s) * ADDR_WIDTH'(WPR) + ADDR_WIDTH'(col_s[6:2]);
        hit_s    = cursor_en_i && (col_s == cursor_col_i) && (row_s == {1'b0, cursor_row_i});
    end

    // Stage 1 register: buffer read address plus what stage 2 needs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vr_addr_o   <= {ADDR_WIDTH{1'b0}};
            lane_r      <= 2'd0;
            glyph_row_r <= 4'd0;
        end else begin
            vr_addr_o   <= active_s ? addr_s : {ADDR_WIDTH{1'b0}};
            lane_r      <= col_s[1:0];
            glyph_row_r <= vcount_i[3:0];
        end
    end

    // Stage 2 lane select out of the packed four-character word.
    always_comb begin
        case (lane_r)
            2'd0:    char_s = buf_data_i[0*SINGLE_DATA +: SINGLE_DATA];
            2'd1:    char_s = buf_data_i[1*SINGLE_DATA +: SINGLE_DATA];
            2'd2:    char_s = buf_data_i[2*SINGLE_DATA +: SINGLE_DATA];
            2'd3:    char_s = buf_data_i[3*SINGLE_DATA +: SINGLE_DATA];
            default: char_s = buf_data_i[SINGLE_DATA-1:0];
        endcase
    end

    // Stage 2 register: font ROM address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            font_addr_o <= {FONT_ADDR_WIDTH{1'b0}};
        end else begin
            font_addr_o <= FONT_ADDR_WIDTH'({char_s, glyph_row_r});
        end
    end

    // Sidebands ride two stages so they meet the font data in stage 3.
    assign side_s = {active_s, hit_s, hcount_i[2:0]};

    vga_delay_line #(
        .WIDTH     (5),
        .DEPTH     (2),
        .RESET_VAL (5'b00000)
    ) u_side_delay (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (side_s),
        .q_o    (side_d_s)
    );

    assign active_d_s = side_d_s[4];
    assign hit_d_s    = side_d_s[3];
    assign hpix_d_s   = side_d_s[2:0];

    // Syncs take three stages, the last of which is the output register.
    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (3),
        .RESET_VAL ({SYNC_IDLE, SYNC_IDLE})
    ) u_sync_delay (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    ({hsync_i, vsync_i}),
        .q_o    (sync_d_s)
    );

    assign hsync_o = sync_d_s[1];
    assign vsync_o = sync_d_s[0];

    // Frame counter advances on each falling edge of the raw vsync.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vsync_prev_r <= SYNC_IDLE;
            frame_cnt_r  <= 5'd0;
        end else begin
            vsync_prev_r <= vsync_i;
            if (vsync_prev_r && !vsync_i) begin
                frame_cnt_r <= frame_cnt_r + 5'd1;
            end
        end
    end

    // Stage 3 pixel: pick the glyph bit, invert under a lit cursor.
    always_comb begin
        blink_s   = frame_cnt_r[4];
        pix_bit_s = font_data_i[3'd7 - hpix_d_s];
        if (!active_d_s) begin
            rgb_s = {COLOR_WIDTH{1'b0}};
        end else if (pix_bit_s ^ (hit_d_s & blink_s)) begin
            rgb_s = fg_color_i;
        end else begin
            rgb_s = bg_color_i;
        end
    end

    // Stage 3 register: pixel colour.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rgb_o <= {COLOR_WIDTH{1'b0}};
        end else begin
            rgb_o <= rgb_s;
        end
    end

endmodule

// File: tb/tb_vga_tile_fetch.sv
// Scoreboard bench for vga_tile_fetch: stimulus queues expected addresses and
// pixels with their due cycle; a negedge monitor pops and compares.
module tb_vga_tile_fetch;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [9:0]  hcount_i, vcount_i;
    logic        hsync_i, vsync_i;
    logic [9:0]  vr_addr_o;
    logic [27:0] buf_data_i;
    logic [10:0] font_addr_o;
    logic [7:0]  font_data_i;
    logic [11:0] fg_color_i, bg_color_i;
    logic        cursor_en_i;
    logic [6:0]  cursor_col_i;
    logic [4:0]  cursor_row_i;
    logic [11:0] rgb_o;
    logic        hsync_o, vsync_o;

    vga_tile_fetch dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .hcount_i     (hcount_i),
        .vcount_i     (vcount_i),
        .hsync_i      (hsync_i),
        .vsync_i      (vsync_i),
        .vr_addr_o    (vr_addr_o),
        .buf_data_i   (buf_data_i),
        .font_addr_o  (font_addr_o),
        .font_data_i  (font_data_i),
        .fg_color_i   (fg_color_i),
        .bg_color_i   (bg_color_i),
        .cursor_en_i  (cursor_en_i),
        .cursor_col_i (cursor_col_i),
        .cursor_row_i (cursor_row_i),
        .rgb_o        (rgb_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o)
    );

    always #20 clk_i = ~clk_i;

    // Buffer model answers the current read address.
    logic [27:0] bufmem [0:1023];
    assign buf_data_i = bufmem[vr_addr_o];

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t addr_q[$];
    exp_t font_q[$];
    exp_t pix_q[$];

    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    logic [4:0] frames = 5'd0;
    logic     last_vs  = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endfunction

    // Reference pixel: glyph bit, MSB leftmost, inverted by a lit cursor.
    function automatic logic [11:0] pix_exp(int h, int v);
        logic b;
        logic hit;
        if (h >= 640 || v >= 480) return 12'h000;
        b   = font_data_i[7 - (h % 8)];
        hit = cursor_en_i && ((h / 8) == int'(cursor_col_i)) && ((v / 16) == int'(cursor_row_i));
        if (b ^ (hit & frames[4])) return fg_color_i;
        return bg_color_i;
    endfunction

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            if (e.due != cyc) chk("vr_addr_slot", 32'(cyc), 32'(e.due));
            else              chk("vr_addr", 32'(vr_addr_o), e.val);
        end
        if (font_q.size() > 0 && font_q[0].due <= cyc) begin
            e = font_q.pop_front();
            if (e.due != cyc) chk("font_addr_slot", 32'(cyc), 32'(e.due));
            else              chk("font_addr", 32'(font_addr_o), e.val);
        end
        if (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            e = pix_q.pop_front();
            if (e.due != cyc) begin
                chk("pix_slot", 32'(cyc), 32'(e.due));
            end else begin
                chk("rgb", 32'(rgb_o), 32'(e.val[11:0]));
                chk("hsync", 32'(hsync_o), 32'(e.val[12]));
                chk("vsync", 32'(vsync_o), 32'(e.val[13]));
            end
        end
    end

    // One pixel clock of stimulus; optionally queue its pixel/sync expectation.
    task automatic apply(input int h, input int v, input logic hs, input logic vs, input bit chk_pix);
        hcount_i = 10'(h);
        vcount_i = 10'(v);
        hsync_i  = hs;
        vsync_i  = vs;
        if (last_vs && !vs) frames = frames + 5'd1;
        last_vs = vs;
        if (chk_pix) pix_q.push_back('{due: cyc + 3, val: {18'd0, vs, hs, pix_exp(h, v)}});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(700, 500, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic vsync_edges(input int n);
        for (int i = 0; i < n; i++) begin
            apply(700, 500, 1'b1, 1'b0, 1'b1);
            apply(700, 500, 1'b1, 1'b1, 1'b1);
        end
        idle(4);
    endtask

    task automatic cursor_rows();
        int rows[3] = '{32, 47, 48};
        for (int r = 0; r < 3; r++) begin
            for (int h = 16; h < 40; h++) apply(h, rows[r], 1'b1, 1'b1, 1'b1);
        end
        idle(4);
    endtask

    // Directed address / lane vectors; fexp < 0 means font address unchecked.
    int at_h[10] = '{0, 7, 32, 639, 640, 0, 100, 16, 8, 24};
    int at_v[10] = '{0, 0, 0, 479, 0, 480, 37, 5, 5, 15};
    int at_a[10] = '{0, 0, 1, 599, 0, 0, 43, 0, 0, 0};
    int at_f[10] = '{'h410, 'h410, -1, 'h11F, -1, -1, 'h2A5, 'h435, 'h425, 'h44F};

    initial begin
        for (int i = 0; i < 1024; i++) bufmem[i] = 28'h0;
        bufmem[0]   = {7'h44, 7'h43, 7'h42, 7'h41};
        bufmem[43]  = {7'h7F, 7'h00, 7'h55, 7'h2A};
        bufmem[599] = {7'h11, 7'h22, 7'h33, 7'h44};
        rstn_i       = 1'b0;
        hcount_i     = 10'd0;
        vcount_i     = 10'd0;
        hsync_i      = 1'b1;
        vsync_i      = 1'b1;
        font_data_i  = 8'hFF;
        fg_color_i   = 12'hABC;
        bg_color_i   = 12'h123;
        cursor_en_i  = 1'b0;
        cursor_col_i = 7'd3;
        cursor_row_i = 5'd2;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            hcount_i    = 10'($urandom_range(0, 639));
            vcount_i    = 10'($urandom_range(0, 479));
            hsync_i     = ~hsync_i;
            vsync_i     = ~vsync_i;
            font_data_i = 8'($urandom);
            @(negedge clk_i);
            chk("rst_rgb", 32'(rgb_o), 32'h0);
            chk("rst_hsync", 32'(hsync_o), 32'h1);
            chk("rst_vsync", 32'(vsync_o), 32'h1);
            chk("rst_vr_addr", 32'(vr_addr_o), 32'h0);
            chk("rst_font_addr", 32'(font_addr_o), 32'h0);
        end
        @(posedge clk_i);
        #1;
        hcount_i = 10'd700;
        vcount_i = 10'd500;
        hsync_i  = 1'b1;
        vsync_i  = 1'b1;
        rstn_i   = 1'b1;
        @(posedge clk_i);
        #1;
        idle(3);

        // Address map and lane unpack.
        for (int h = 0; h < 8; h++) begin
            addr_q.push_back('{due: cyc + 1, val: 32'd0});
            apply(h, 0, 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            addr_q.push_back('{due: cyc + 1, val: 32'(at_a[i])});
            if (at_f[i] >= 0) font_q.push_back('{due: cyc + 2, val: 32'(at_f[i])});
            apply(at_h[i], at_v[i], 1'b1, 1'b1, 1'b0);
        end
        idle(4);

        // Pixel order and sync alignment.
        font_data_i = 8'b1000_0001;
        idle(4);
        for (int h = 0; h < 8; h++) apply(h, 0, (h % 3 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        idle(4);

        // Blanking.
        font_data_i = 8'hFF;
        idle(4);
        for (int h = 640; h < 800; h++) apply(h, 0, (h >= 656 && h < 752) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        for (int v = 480; v < 484; v++) apply(0, v, 1'b1, 1'b1, 1'b1);
        idle(4);

        // Cursor blink: on after 16 edges, off after 32, never when disabled.
        font_data_i = 8'hF0;
        cursor_en_i = 1'b1;
        idle(4);
        vsync_edges(16);
        cursor_rows();
        vsync_edges(16);
        cursor_rows();
        cursor_en_i = 1'b0;
        vsync_edges(16);
        cursor_rows();

        idle(6);
        chk("queue_drain", 32'(addr_q.size() + font_q.size() + pix_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
